// File: rtl/wb_stage.sv
// Write-back stage: load extension, write-back select, integer register file,
// WB->EX forwarding register and retire counter. `WB_BYPASS_EN selects a write-through register file.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_wb,
    input  logic [4:0]  rd_wb,
    input  logic [2:0]  func3_wb,
    input  logic [6:0]  opcode_wb,
    input  logic [31:0] data_out_wb,
    input  logic        lt_wb,
    input  logic        ltu_wb,
    input  logic [31:0] result_wb,
    input  logic [31:0] pc_wb,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic [63:0] instret
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [31:0] regs_q [32];
    logic        fwd_valid_q;
    logic [4:0]  fwd_rd_q;
    logic [31:0] fwd_data_q;
    logic [63:0] instret_q;
    logic [63:0] instret_d;
    logic        writes_class;
    logic        retire;

    always_comb begin
        wb_data      = result_wb;
        writes_class = 1'b0;
        case (opcode_wb)
            OPC_LOAD: begin
                writes_class = 1'b1;
                case (func3_wb)
                    3'b000:  wb_data = {{24{data_out_wb[7]}}, data_out_wb[7:0]};
                    3'b001:  wb_data = {{16{data_out_wb[15]}}, data_out_wb[15:0]};
                    3'b100:  wb_data = {24'b0, data_out_wb[7:0]};
                    3'b101:  wb_data = {16'b0, data_out_wb[15:0]};
                    default: wb_data = data_out_wb;
                endcase
            end
            OPC_OP, OPC_OP_IMM: begin
                writes_class = 1'b1;
                case (func3_wb)
                    3'b010:  wb_data = {31'b0, lt_wb};
                    3'b011:  wb_data = {31'b0, ltu_wb};
                    default: wb_data = result_wb;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                writes_class = 1'b1;
                wb_data      = result_wb;
            end
            OPC_JAL, OPC_JALR: begin
                writes_class = 1'b1;
                wb_data      = pc_wb + 32'd4;
            end
            default: begin
                writes_class = 1'b0;
                wb_data      = result_wb;
            end
        endcase
        // rd = 0 is filtered here, so x0 in the array is never touched
        wb_en = valid_wb & writes_class & (rd_wb != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[rd_wb] <= wb_data;
        end
    end

    assign retire    = valid_wb & (opcode_wb != 7'd0);
    assign instret_d = instret_q + {63'd0, retire};

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
            fwd_rd_q    <= '0;
            fwd_data_q  <= '0;
            instret_q   <= '0;
        end else begin
            fwd_valid_q <= wb_en;
            fwd_rd_q    <= rd_wb;
            fwd_data_q  <= wb_data;
            instret_q   <= instret_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [4:0]  port_addr;
        logic [31:0] port_data;
        assign port_addr = (gi == 0) ? rs1_addr : rs2_addr;
        always_comb begin
            port_data = regs_q[port_addr];
`ifdef WB_BYPASS_EN
            if (wb_en && (port_addr == rd_wb)) begin
                port_data = wb_data;
            end
`endif
            if (port_addr == 5'd0) begin
                port_data = '0;
            end
        end
    end

    assign rs1_data  = g_rd[0].port_data;
    assign rs2_data  = g_rd[1].port_data;
    assign fwd_valid = fwd_valid_q;
    assign fwd_rd    = fwd_rd_q;
    assign fwd_data  = fwd_data_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: decode vector table, directed sequences and randomized
// traffic against an architectural model of the register file and counters.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_wb;
    logic [4:0]  rd_wb;
    logic [2:0]  func3_wb;
    logic [6:0]  opcode_wb;
    logic [31:0] data_out_wb;
    logic        lt_wb;
    logic        ltu_wb;
    logic [31:0] result_wb;
    logic [31:0] pc_wb;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [31:0] wb_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [63:0] instret;

    int n_checks = 0;
    int n_pass   = 0;

    wb_stage dut (
        .clk(clk), .rst(rst), .valid_wb(valid_wb), .rd_wb(rd_wb),
        .func3_wb(func3_wb), .opcode_wb(opcode_wb), .data_out_wb(data_out_wb),
        .lt_wb(lt_wb), .ltu_wb(ltu_wb), .result_wb(result_wb), .pc_wb(pc_wb),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .wb_en(wb_en), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .instret(instret)
    );

    always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // architectural model state
    logic [31:0] m_regs [32];
    logic [63:0] m_instret;
    bit          m_fwd_valid;
    logic [4:0]  m_fwd_rd;
    logic [31:0] m_fwd_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] sext(input logic [31:0] raw, input int bits);
        longint v;
        longint span;
        span = longint'(1) << bits;
        v = longint'(raw) % span;
        if (v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // expected write-back from the instruction-class rules
    task automatic ref_wb(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] d,
                          input logic lt, input logic ltu, input logic [31:0] res,
                          input logic [31:0] pc, input logic v, input logic [4:0] rd,
                          output bit en, output logic [31:0] val);
        bit writes;
        longint link;
        writes = 1'b1;
        val = res;
        case (op)
            7'h03: begin
                if (f3 == 0)      val = sext(d, 8);
                else if (f3 == 1) val = sext(d, 16);
                else if (f3 == 4) val = d % 256;
                else if (f3 == 5) val = d % 65536;
                else              val = d;
            end
            7'h33, 7'h13: begin
                if (f3 == 2)      val = lt ? 1 : 0;
                else if (f3 == 3) val = ltu ? 1 : 0;
            end
            7'h37, 7'h17: val = res;
            7'h6F, 7'h67: begin
                link = (longint'(pc) + 4) % (longint'(1) << 32);
                val = link[31:0];
            end
            default: writes = 1'b0;
        endcase
        en = v && writes && (rd != 0);
    endtask

    task automatic apply(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] d, input logic lt,
                         input logic ltu, input logic [31:0] res, input logic [31:0] pc);
        valid_wb = v; opcode_wb = op; func3_wb = f3; rd_wb = rd; data_out_wb = d;
        lt_wb = lt; ltu_wb = ltu; result_wb = res; pc_wb = pc;
    endtask

    task automatic idle();
        apply(1'b0, 7'h00, 3'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        lt;
        logic        ltu;
        logic [31:0] res;
        logic [31:0] pc;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    initial begin
        bit          e_en;
        logic [31:0] e_val;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;

        vecs[0]  = '{"lb",      1, 7'h03, 3'd0, 5'd5, 32'h0000_00F0, 0, 0, 32'h0,     32'h0, 1, 32'hFFFF_FFF0};
        vecs[1]  = '{"lbu",     1, 7'h03, 3'd4, 5'd5, 32'h0000_00F0, 0, 0, 32'h0,     32'h0, 1, 32'h0000_00F0};
        vecs[2]  = '{"lh",      1, 7'h03, 3'd1, 5'd6, 32'h0000_8001, 0, 0, 32'h0,     32'h0, 1, 32'hFFFF_8001};
        vecs[3]  = '{"lhu",     1, 7'h03, 3'd5, 5'd6, 32'hABCD_8001, 0, 0, 32'h0,     32'h0, 1, 32'h0000_8001};
        vecs[4]  = '{"lw",      1, 7'h03, 3'd2, 5'd6, 32'hABCD_8001, 0, 0, 32'h0,     32'h0, 1, 32'hABCD_8001};
        vecs[5]  = '{"ld_f3_7", 1, 7'h03, 3'd7, 5'd6, 32'h8000_0080, 0, 0, 32'h0,     32'h0, 1, 32'h8000_0080};
        vecs[6]  = '{"sltu",    1, 7'h33, 3'd3, 5'd8, 32'h0,         0, 1, 32'hDEAD,  32'h0, 1, 32'h0000_0001};
        vecs[7]  = '{"slti",    1, 7'h13, 3'd2, 5'd8, 32'h0,         0, 1, 32'hDEAD,  32'h0, 1, 32'h0000_0000};
        vecs[8]  = '{"add",     1, 7'h33, 3'd0, 5'd8, 32'h0,         1, 1, 32'h1234,  32'h0, 1, 32'h0000_1234};
        vecs[9]  = '{"jal_wrap",1, 7'h6F, 3'd0, 5'd1, 32'h0,         0, 0, 32'h0,     32'hFFFF_FFFC, 1, 32'h0};
        vecs[10] = '{"store",   1, 7'h23, 3'd2, 5'd7, 32'h0,         0, 0, 32'h77,    32'h0, 0, 32'h0000_0077};
        vecs[11] = '{"bubble",  0, 7'h33, 3'd0, 5'd7, 32'h0,         0, 0, 32'h99,    32'h0, 0, 32'h0000_0099};
        vecs[12] = '{"rd0",     1, 7'h13, 3'd0, 5'd0, 32'h0,         0, 0, 32'h55,    32'h0, 0, 32'h0000_0055};
        vecs[13] = '{"lui",     1, 7'h37, 3'd5, 5'd9, 32'h0,         1, 1, 32'hABCD_E000, 32'h0, 1, 32'hABCD_E000};

        rst = 1'b1; rs1_addr = 0; rs2_addr = 0;
        idle();
        tick(); tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = a[4:0]; rs2_addr = 5'(31 - a);
            #1;
            check($sformatf("reset_rs1_x%0d", a), {32'd0, rs1_data}, 64'd0);
            check($sformatf("reset_rs2_x%0d", 31 - a), {32'd0, rs2_data}, 64'd0);
        end
        check("reset_instret", instret, 64'd0);
        check("reset_fwd_valid", {63'd0, fwd_valid}, 64'd0);

        // combinational decode table (held in reset so no state changes)
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].v, vecs[i].op, vecs[i].f3, vecs[i].rd, vecs[i].d,
                  vecs[i].lt, vecs[i].ltu, vecs[i].res, vecs[i].pc);
            #1;
            check({vecs[i].name, "_en"}, {63'd0, wb_en}, {63'd0, vecs[i].exp_en});
            check({vecs[i].name, "_data"}, {32'd0, wb_data}, {32'd0, vecs[i].exp_data});
        end
        tick();
        rst = 1'b0;
        idle();
        tick();

        // directed register-file sequences
        apply(1, 7'h03, 3'd0, 5'd5, 32'h0000_00F0, 0, 0, 0, 0); tick();
        apply(1, 7'h6F, 3'd0, 5'd1, 0, 0, 0, 0, 32'h0000_0100); tick();
        apply(1, 7'h13, 3'd0, 5'd0, 0, 0, 0, 32'h55, 0);
        #1;
        check("addi_x0_wb_en", {63'd0, wb_en}, 64'd0);
        tick();
        apply(1, 7'h23, 3'd2, 5'd7, 0, 0, 0, 32'h77, 0); tick();
        apply(0, 7'h33, 3'd0, 5'd7, 0, 0, 0, 32'h99, 0); tick();
        idle();
        rs1_addr = 5; rs2_addr = 1; #1;
        check("x5_lb", {32'd0, rs1_data}, 64'h0000_0000_FFFF_FFF0);
        check("x1_jal", {32'd0, rs2_data}, 64'h104);
        rs1_addr = 0; rs2_addr = 7; #1;
        check("x0_zero", {32'd0, rs1_data}, 64'd0);
        check("x7_unchanged", {32'd0, rs2_data}, 64'd0);
        check("instret_after_seq", instret, 64'd4);

        // same-cycle read of a register being written
        apply(1, 7'h13, 3'd0, 5'd3, 0, 0, 0, 32'h1111_1111, 0); tick();
        apply(1, 7'h13, 3'd0, 5'd3, 0, 0, 0, 32'h1234_5678, 0);
        rs1_addr = 3; #1;
        check("bypass_same_cycle", {32'd0, rs1_data},
              BYPASS ? 64'h1234_5678 : 64'h1111_1111);
        tick();
        idle();
        #1;
        check("bypass_next_cycle", {32'd0, rs1_data}, 64'h1234_5678);
        check("fwd_valid", {63'd0, fwd_valid}, 64'd1);
        check("fwd_rd", {59'd0, fwd_rd}, 64'd3);
        check("fwd_data", {32'd0, fwd_data}, 64'h1234_5678);

        // reset beats a simultaneous write
        apply(1, 7'h13, 3'd0, 5'd9, 0, 0, 0, 32'hAAAA, 0);
        rst = 1'b1; tick();
        rst = 1'b0; idle(); rs1_addr = 9; #1;
        check("rst_prio_x9", {32'd0, rs1_data}, 64'd0);
        check("rst_prio_instret", instret, 64'd0);

        // counter wrap
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        apply(1, 7'h13, 3'd0, 5'd2, 0, 0, 0, 32'h1, 0); tick();
        idle(); #1;
        check("instret_wrap", instret, 64'd0);

        // randomized traffic against the model
        rst = 1'b1; tick(); rst = 1'b0;
        for (int a = 0; a < 32; a++) m_regs[a] = '0;
        m_instret = 0; m_fwd_valid = 0; m_fwd_rd = 0; m_fwd_data = 0;
        for (int n = 0; n < 400; n++) begin
            logic [6:0] ops [11];
            bit do_rst;
            ops = '{7'h03, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h23, 7'h63, 7'h00, 7'h7F};
            do_rst = ($urandom_range(0, 39) == 0);
            rst = do_rst;
            apply($urandom_range(0, 7) != 0, ops[$urandom_range(0, 10)], 3'($urandom),
                  5'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom),
                  $urandom, $urandom);
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            #2;
            ref_wb(opcode_wb, func3_wb, data_out_wb, lt_wb, ltu_wb, result_wb,
                   pc_wb, valid_wb, rd_wb, e_en, e_val);
            e_rd1 = (BYPASS && e_en && rd_wb == rs1_addr) ? e_val : m_regs[rs1_addr];
            e_rd2 = (BYPASS && e_en && rd_wb == rs2_addr) ? e_val : m_regs[rs2_addr];
            if (rs1_addr == 0) e_rd1 = 0;
            if (rs2_addr == 0) e_rd2 = 0;
            check("rnd_wb_en", {63'd0, wb_en}, {63'd0, e_en});
            if (e_en) check("rnd_wb_data", {32'd0, wb_data}, {32'd0, e_val});
            check("rnd_rs1", {32'd0, rs1_data}, {32'd0, e_rd1});
            check("rnd_rs2", {32'd0, rs2_data}, {32'd0, e_rd2});
            @(posedge clk);
            if (do_rst) begin
                for (int a = 0; a < 32; a++) m_regs[a] = '0;
                m_instret = 0; m_fwd_valid = 0; m_fwd_rd = 0; m_fwd_data = 0;
            end else begin
                if (e_en) m_regs[rd_wb] = e_val;
                if (valid_wb && opcode_wb != 0) m_instret = m_instret + 1;
                m_fwd_valid = e_en; m_fwd_rd = rd_wb; m_fwd_data = e_val;
            end
            #1;
            check("rnd_instret", instret, m_instret);
            check("rnd_fwd_valid", {63'd0, fwd_valid}, {63'd0, m_fwd_valid});
            if (m_fwd_valid) begin
                check("rnd_fwd_rd", {59'd0, fwd_rd}, {59'd0, m_fwd_rd});
                check("rnd_fwd_data", {32'd0, fwd_data}, {32'd0, m_fwd_data});
            end
        end
        rst = 1'b0;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
